// File: rtl/led_hex_scan_driver.sv
// led_hex_scan_driver
// Scans a 32-bit word onto an 8-digit multiplexed common-anode seven-segment
// display, one hex digit per slot, with a blanking gap at the start of every
// slot. Input data is captured into shadow registers only at frame
// boundaries (or on scan start), so a frame never mixes old and new data.
// All pin outputs are registered and go dark asynchronously on reset.
module led_hex_scan_driver #(
  parameter int PRESCALE     = 5000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_in,
  input  logic        lz_suppress,
  input  logic        enable,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [7:0]  dig_n,
  output logic        frame_tick
);

  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);
  localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  state_t      state_q;
  logic [15:0] presc_q;
  logic [2:0]  digit_q;
  logic [31:0] shadow_data_q;
  logic [7:0]  shadow_dp_q;
  logic        shadow_lz_q;
  logic        frame_tick_q;

  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic [7:0]  dig_q, dig_d;

  logic [3:0]  nibble_s;
  logic        lz_blank_s;

  // Active-high segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0:    hex7 = 7'h3F;
      4'h1:    hex7 = 7'h06;
      4'h2:    hex7 = 7'h5B;
      4'h3:    hex7 = 7'h4F;
      4'h4:    hex7 = 7'h66;
      4'h5:    hex7 = 7'h6D;
      4'h6:    hex7 = 7'h7D;
      4'h7:    hex7 = 7'h07;
      4'h8:    hex7 = 7'h7F;
      4'h9:    hex7 = 7'h6F;
      4'hA:    hex7 = 7'h77;
      4'hB:    hex7 = 7'h7C;
      4'hC:    hex7 = 7'h39;
      4'hD:    hex7 = 7'h5E;
      4'hE:    hex7 = 7'h79;
      4'hF:    hex7 = 7'h71;
      default: hex7 = 7'h00;
    endcase
  endfunction

  assign nibble_s = shadow_data_q[{digit_q, 2'b00} +: 4];
  // A digit is a leading zero when it and every more-significant nibble are zero.
  assign lz_blank_s = shadow_lz_q && (digit_q != 3'd0) &&
                      ((shadow_data_q >> {digit_q, 2'b00}) == 32'd0);

  // Scan FSM: slot prescaler, digit index, shadow capture and frame pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      presc_q       <= 16'd0;
      digit_q       <= 3'd0;
      shadow_data_q <= 32'd0;
      shadow_dp_q   <= 8'd0;
      shadow_lz_q   <= 1'b0;
      frame_tick_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          presc_q      <= 16'd0;
          digit_q      <= 3'd0;
          frame_tick_q <= 1'b0;
          if (enable) begin
            state_q       <= ST_BLANK;
            shadow_data_q <= data_in;
            shadow_dp_q   <= dp_in;
            shadow_lz_q   <= lz_suppress;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_BLANK, ST_DRIVE: begin
          // The frame pulse fires even if enable drops on the same cycle.
          frame_tick_q <= (presc_q == PRESC_LAST) && (digit_q == 3'd7);
          if (!enable) begin
            state_q <= ST_IDLE;
            presc_q <= 16'd0;
            digit_q <= 3'd0;
          end else if (presc_q == PRESC_LAST) begin
            presc_q <= 16'd0;
            digit_q <= digit_q + 3'd1;
            state_q <= ST_BLANK;
            if (digit_q == 3'd7) begin
              shadow_data_q <= data_in;
              shadow_dp_q   <= dp_in;
              shadow_lz_q   <= lz_suppress;
            end
          end else begin
            presc_q <= presc_q + 16'd1;
            state_q <= (presc_q >= BLANK_LAST) ? ST_DRIVE : ST_BLANK;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          presc_q      <= 16'd0;
          digit_q      <= 3'd0;
          frame_tick_q <= 1'b0;
        end
      endcase
    end
  end

  // Pin decode: only DRIVE cycles light a digit; everything else is dark.
  always_comb begin
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    dig_d = 8'hFF;
    if (state_q == ST_DRIVE) begin
      dig_d = ~(8'd1 << digit_q);
      dp_d  = ~shadow_dp_q[digit_q];
      if (lz_blank_s) begin
        seg_d = 7'h7F;
      end else begin
        seg_d = ~hex7(nibble_s);
      end
    end else begin
      seg_d = 7'h7F;
      dp_d  = 1'b1;
      dig_d = 8'hFF;
    end
  end

  // Pin registers; reset darkens the display without waiting for a clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
      dig_q <= 8'hFF;
    end else begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
      dig_q <= dig_d;
    end
  end

  assign seg_n      = seg_q;
  assign dp_n       = dp_q;
  assign dig_n      = dig_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_led_hex_scan_driver.sv
// Directed bench for led_hex_scan_driver with PRESCALE=8, BLANK_CYCLES=2.
// Inputs change and outputs are sampled on the falling clock edge.
// Sample s counts falling edges after enable is raised: pins are dark at
// s=1, then each 8-sample slot for digit k spans s=2+8k..9+8k with the
// first two samples dark (blanking) and the remaining six driven.
module tb_led_hex_scan_driver;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] data_in;
  logic [7:0]  dp_in;
  logic        lz_suppress;
  logic        enable;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [7:0]  dig_n;
  logic        frame_tick;

  int tests_run    = 0;
  int tests_failed = 0;

  led_hex_scan_driver #(.PRESCALE(8), .BLANK_CYCLES(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .data_in     (data_in),
    .dp_in       (dp_in),
    .lz_suppress (lz_suppress),
    .enable      (enable),
    .seg_n       (seg_n),
    .dp_n        (dp_n),
    .dig_n       (dig_n),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic go_idle();
    enable = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; data_in = 32'd0; dp_in = 8'd0; lz_suppress = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({seg_n, dp_n, dig_n, frame_tick} !== {7'h7F, 1'b1, 8'hFF, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_hold: got seg=%h dp=%b dig=%h ft=%b, want 7f 1 ff 0", seg_n, dp_n, dig_n, frame_tick);
    end
    reset_n = 1'b1;
    for (int s = 0; s < 20; s++) begin
      @(negedge clk);
      tests_run++;
      if ({seg_n, dp_n, dig_n, frame_tick} !== {7'h7F, 1'b1, 8'hFF, 1'b0}) begin
        tests_failed++;
        $display("FAIL idle_dark c=%0d: got seg=%h dp=%b dig=%h ft=%b, want 7f 1 ff 0", s, seg_n, dp_n, dig_n, frame_tick);
      end
    end
  endtask

  task automatic test_hex_scan();
    logic [6:0] pat [8];
    logic [7:0] exp_dig;
    logic [6:0] exp_seg;
    logic       exp_ft;
    int         k;
    pat = '{~7'h71, ~7'h39, ~7'h7C, ~7'h77, ~7'h4F, ~7'h5B, ~7'h06, ~7'h3F};
    go_idle();
    data_in = 32'h0123ABCF; dp_in = 8'h00; lz_suppress = 1'b0; enable = 1'b1;
    for (int s = 1; s <= 130; s++) begin
      @(negedge clk);
      exp_dig = 8'hFF; exp_seg = 7'h7F; exp_ft = 1'b0;
      if (s >= 2) begin
        k = ((s - 2) / 8) % 8;
        if (((s - 2) % 8) >= 2) begin
          exp_dig = ~(8'd1 << k);
          exp_seg = pat[k];
        end
        if (((s - 2) % 64) == 63) exp_ft = 1'b1;
      end
      tests_run++;
      if ({dig_n, seg_n, dp_n, frame_tick} !== {exp_dig, exp_seg, 1'b1, exp_ft}) begin
        tests_failed++;
        $display("FAIL hex_scan s=%0d: got dig=%h seg=%h dp=%b ft=%b, want dig=%h seg=%h dp=1 ft=%b",
                 s, dig_n, seg_n, dp_n, frame_tick, exp_dig, exp_seg, exp_ft);
      end
    end
  endtask

  task automatic test_shadow_latch();
    logic [7:0] exp_dig;
    logic [6:0] exp_seg;
    go_idle();
    data_in = 32'h11111111; dp_in = 8'h00; lz_suppress = 1'b0; enable = 1'b1;
    for (int s = 1; s <= 129; s++) begin
      @(negedge clk);
      exp_dig = 8'hFF; exp_seg = 7'h7F;
      if (s >= 2 && ((s - 2) % 8) >= 2) begin
        exp_dig = ~(8'd1 << (((s - 2) / 8) % 8));
        exp_seg = (s <= 65) ? 7'h79 : 7'h24;
      end
      tests_run++;
      if ({dig_n, seg_n} !== {exp_dig, exp_seg}) begin
        tests_failed++;
        $display("FAIL shadow_latch s=%0d: got dig=%h seg=%h, want dig=%h seg=%h", s, dig_n, seg_n, exp_dig, exp_seg);
      end
      if (s == 30) data_in = 32'h22222222;
    end
  endtask

  task automatic test_lz_suppress();
    logic [6:0] pat [8];
    logic [7:0] exp_dig;
    logic [6:0] exp_seg;
    logic       exp_dp;
    int         k;
    for (int c = 0; c < 2; c++) begin
      go_idle();
      if (c == 0) begin
        data_in = 32'h00000A00; dp_in = 8'h81;
        pat = '{7'h40, 7'h40, 7'h08, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
      end else begin
        data_in = 32'h00000000; dp_in = 8'h00;
        pat = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
      end
      lz_suppress = 1'b1; enable = 1'b1;
      for (int s = 1; s <= 65; s++) begin
        @(negedge clk);
        exp_dig = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1;
        if (s >= 2 && ((s - 2) % 8) >= 2) begin
          k = (s - 2) / 8;
          exp_dig = ~(8'd1 << k);
          exp_seg = pat[k];
          exp_dp  = (c == 0 && (k == 0 || k == 7)) ? 1'b0 : 1'b1;
        end
        tests_run++;
        if ({dig_n, seg_n, dp_n} !== {exp_dig, exp_seg, exp_dp}) begin
          tests_failed++;
          $display("FAIL lz_suppress c=%0d s=%0d: got dig=%h seg=%h dp=%b, want dig=%h seg=%h dp=%b",
                   c, s, dig_n, seg_n, dp_n, exp_dig, exp_seg, exp_dp);
        end
      end
    end
  endtask

  task automatic test_enable_drop();
    logic [7:0] exp_dig;
    logic [6:0] exp_seg;
    go_idle();
    data_in = 32'h00500000; dp_in = 8'h00; lz_suppress = 1'b0; enable = 1'b1;
    for (int s = 1; s <= 50; s++) begin
      @(negedge clk);
      if (s == 46) begin
        tests_run++;
        if ({dig_n, seg_n} !== {8'hDF, 7'h12}) begin
          tests_failed++;
          $display("FAIL enable_drop_lag: got dig=%h seg=%h, want dig=df seg=12", dig_n, seg_n);
        end
      end
      if (s >= 47) begin
        tests_run++;
        if ({dig_n, seg_n, dp_n, frame_tick} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
          tests_failed++;
          $display("FAIL enable_drop_dark s=%0d: got dig=%h seg=%h dp=%b ft=%b, want ff 7f 1 0", s, dig_n, seg_n, dp_n, frame_tick);
        end
      end
      if (s == 45) enable = 1'b0;
    end
    data_in = 32'h0000000E; enable = 1'b1;
    for (int s = 1; s <= 11; s++) begin
      @(negedge clk);
      exp_dig = 8'hFF; exp_seg = 7'h7F;
      if (s >= 4 && s <= 9) begin
        exp_dig = 8'hFE; exp_seg = 7'h06;
      end
      tests_run++;
      if ({dig_n, seg_n} !== {exp_dig, exp_seg}) begin
        tests_failed++;
        $display("FAIL restart s=%0d: got dig=%h seg=%h, want dig=%h seg=%h", s, dig_n, seg_n, exp_dig, exp_seg);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    go_idle();
    data_in = 32'h00000300; dp_in = 8'h04; lz_suppress = 1'b0; enable = 1'b1;
    repeat (21) @(negedge clk);
    tests_run++;
    if ({dig_n, seg_n, dp_n} !== {8'hFB, 7'h30, 1'b0}) begin
      tests_failed++;
      $display("FAIL pre_reset_drive: got dig=%h seg=%h dp=%b, want dig=fb seg=30 dp=0", dig_n, seg_n, dp_n);
    end
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if ({dig_n, seg_n, dp_n, frame_tick} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL async_reset: got dig=%h seg=%h dp=%b ft=%b, want ff 7f 1 0", dig_n, seg_n, dp_n, frame_tick);
    end
    enable = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      tests_run++;
      if ({dig_n, seg_n, dp_n, frame_tick} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
        tests_failed++;
        $display("FAIL post_reset_dark c=%0d: got dig=%h seg=%h dp=%b ft=%b, want ff 7f 1 0", s, dig_n, seg_n, dp_n, frame_tick);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hex_scan();
    test_shadow_latch();
    test_lz_suppress();
    test_enable_drop();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
